// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with per-digit blanking, PWM brightness and
// frame-latched display data. Define SEG7_LZS_EN to enable leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DUTY_W   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DUTY_W-1:0]     brightness,
    output logic [6:0]            sg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PROD_W = 32 + DUTY_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_LOAD,
        ST_SCAN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   din_sh_q, din_sh_d;
    logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]     blank_sh_q, blank_sh_d;
    logic [6:0]            sg_q, sg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fd_q, fd_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  shadow_load;
    logic [DIGITS-1:0]     lz_mask;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [PROD_W-1:0]     on_prod;
    logic [PROD_W-1:0]     on_cnt;
    logic                  lit;

    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b1111110;
            4'h1:    p = 7'b0110000;
            4'h2:    p = 7'b1101101;
            4'h3:    p = 7'b1111001;
            4'h4:    p = 7'b0110011;
            4'h5:    p = 7'b1011011;
            4'h6:    p = 7'b1011111;
            4'h7:    p = 7'b1110000;
            4'h8:    p = 7'b1111111;
            4'h9:    p = 7'b1111011;
            4'hA:    p = 7'b1110111;
            4'hB:    p = 7'b0011111;
            4'hC:    p = 7'b1001110;
            4'hD:    p = 7'b0111101;
            4'hE:    p = 7'b1001111;
            default: p = 7'b1000111;
        endcase
        return p;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_wrap = slot_end && (idx_q == IDX_LAST);
        cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadows take the inputs once right after reset, then only at frame wraps.
    always_comb begin
        state_d     = ST_SCAN;
        shadow_load = (state_q == ST_LOAD) || frame_wrap;
        din_sh_d    = din_sh_q;
        dp_sh_d     = dp_sh_q;
        blank_sh_d  = blank_sh_q;
        if (shadow_load) begin
            din_sh_d   = din;
            dp_sh_d    = dp_in;
            blank_sh_d = blank_in;
        end
        fd_d = frame_wrap;
    end

`ifdef SEG7_LZS_EN
    // A digit is suppressed when it and every digit above it hold zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (din_sh_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = din_sh_q[4*i +: 4];
                cur_dp    = dp_sh_q[i];
                cur_blank = blank_sh_q[i] || lz_mask[i];
            end
        end
    end

    // Full-width product keeps the all-ones brightness level at exactly SCAN_DIV cycles.
    always_comb begin
        on_prod = (PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(SCAN_DIV);
        on_cnt  = on_prod >> DUTY_W;
        lit     = !cur_blank && (PROD_W'(cnt_q) < on_cnt);
    end

    always_comb begin
        an_d = '1;
        sg_d = 7'h7F;
        dp_d = 1'b1;
        if (!cur_blank) begin
            sg_d = ~seg_pattern(cur_nib);
        end
        if (lit) begin
            dp_d = ~cur_dp;
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; all values come from the _d logic.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            din_sh_q   <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            sg_q       <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            din_sh_q   <= din_sh_d;
            dp_sh_q    <= dp_sh_d;
            blank_sh_q <= blank_sh_d;
            sg_q       <= sg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign sg         = sg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=16, DUTY_W=2; expectations are
// hand-computed and follow SEG7_LZS_EN when the macro is defined for the build.
module tb_seg7_scan_ctrl;

    logic        CLK;
    logic        RST;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [1:0]  brightness;
    logic [6:0]  sg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;   // clock edges since the last reset release

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [6:0] sg;
        logic       dp;
        logic       fd;
    } vec_t;

    vec_t scan_tab[12];

    seg7_scan_ctrl #(
        .DIGITS   (4),
        .SCAN_DIV (16),
        .DUTY_W   (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .din        (din),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .brightness (brightness),
        .sg         (sg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Outputs seen after edge k reflect the scan state t = k-1 (t counts from release).
    task automatic advance_to(input int t);
        while (k < t + 1) begin
            @(posedge CLK);
            #2;
            k++;
        end
    endtask

    task automatic start(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                         input logic [1:0] br);
        @(negedge CLK);
        RST        = 1'b1;
        din        = d;
        dp_in      = dpv;
        blank_in   = bl;
        brightness = br;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        k   = 0;
    endtask

    task automatic count_lit(input int t0, input int t1, output int n);
        n = 0;
        for (int t = t0; t <= t1; t++) begin
            advance_to(t);
            if (an !== 4'hF) n++;
        end
    endtask

    initial begin
        int n_lit;
        int n_fd;
        int first_fd;

        scan_tab[0]  = '{t: 1,   an: 4'hE, sg: 7'h4C, dp: 1'b1, fd: 1'b0};
        scan_tab[1]  = '{t: 15,  an: 4'hE, sg: 7'h4C, dp: 1'b1, fd: 1'b0};
        scan_tab[2]  = '{t: 16,  an: 4'hD, sg: 7'h06, dp: 1'b1, fd: 1'b0};
        scan_tab[3]  = '{t: 31,  an: 4'hD, sg: 7'h06, dp: 1'b1, fd: 1'b0};
        scan_tab[4]  = '{t: 32,  an: 4'hB, sg: 7'h12, dp: 1'b1, fd: 1'b0};
        scan_tab[5]  = '{t: 47,  an: 4'hB, sg: 7'h12, dp: 1'b1, fd: 1'b0};
        scan_tab[6]  = '{t: 48,  an: 4'h7, sg: 7'h4F, dp: 1'b1, fd: 1'b0};
        scan_tab[7]  = '{t: 62,  an: 4'h7, sg: 7'h4F, dp: 1'b1, fd: 1'b0};
        scan_tab[8]  = '{t: 63,  an: 4'h7, sg: 7'h4F, dp: 1'b1, fd: 1'b1};
        scan_tab[9]  = '{t: 64,  an: 4'hE, sg: 7'h4C, dp: 1'b1, fd: 1'b0};
        scan_tab[10] = '{t: 127, an: 4'h7, sg: 7'h4F, dp: 1'b1, fd: 1'b1};
        scan_tab[11] = '{t: 128, an: 4'hE, sg: 7'h4C, dp: 1'b1, fd: 1'b0};

        // Reset held with all-F data
        RST        = 1'b1;
        din        = 16'hFFFF;
        dp_in      = 4'h0;
        blank_in   = 4'h0;
        brightness = 2'd3;
        repeat (3) @(negedge CLK);
        check("reset an", 32'(an), 32'hF);
        check("reset sg", 32'(sg), 32'h7F);
        check("reset dp", 32'(dp), 32'h1);
        check("reset frame_done", 32'(frame_done), 32'h0);

        // Full-brightness scan of 1234
        start(16'h1234, 4'h0, 4'h0, 2'd3);
        for (int i = 0; i < 12; i++) begin
            advance_to(scan_tab[i].t);
            check($sformatf("scan t=%0d an", scan_tab[i].t), 32'(an), 32'(scan_tab[i].an));
            check($sformatf("scan t=%0d sg", scan_tab[i].t), 32'(sg), 32'(scan_tab[i].sg));
            check($sformatf("scan t=%0d dp", scan_tab[i].t), 32'(dp), 32'(scan_tab[i].dp));
            check($sformatf("scan t=%0d fd", scan_tab[i].t), 32'(frame_done), 32'(scan_tab[i].fd));
        end
        n_fd     = 0;
        first_fd = -1;
        for (int t = 129; t <= 255; t++) begin
            advance_to(t);
            if (frame_done === 1'b1) begin
                n_fd++;
                if (first_fd < 0) first_fd = t;
            end
        end
        check("frame_done pulse count", 32'(n_fd), 32'd2);
        check("frame_done first pulse", 32'(first_fd), 32'd191);

        // Tear-free latch: data change at cycle 20 waits for the next frame
        start(16'h1234, 4'h0, 4'h0, 2'd3);
        advance_to(19);
        din = 16'hABCD;
        advance_to(32);
        check("tear slot2 old", 32'(sg), 32'h12);
        advance_to(48);
        check("tear slot3 old", 32'(sg), 32'h4F);
        advance_to(63);
        check("tear wrap fd", 32'(frame_done), 32'h1);
        check("tear wrap sg old", 32'(sg), 32'h4F);
        advance_to(64);
        check("tear new d0 an", 32'(an), 32'hE);
        check("tear new d0 sg", 32'(sg), 32'h42);
        advance_to(80);
        check("tear new d1 sg", 32'(sg), 32'h31);
        advance_to(96);
        check("tear new d2 sg", 32'(sg), 32'h60);
        advance_to(112);
        check("tear new d3 sg", 32'(sg), 32'h08);

        // Brightness 0 -> 4 of 16 cycles, then 1 -> 8 of 16
        start(16'h1234, 4'h0, 4'h0, 2'd0);
        count_lit(16, 31, n_lit);
        check("bright0 lit cycles", 32'(n_lit), 32'd4);
        advance_to(67);
        check("bright0 cnt3 an", 32'(an), 32'hE);
        advance_to(68);
        check("bright0 cnt4 an", 32'(an), 32'hF);
        advance_to(70);
        brightness = 2'd1;
        count_lit(80, 95, n_lit);
        check("bright1 lit cycles", 32'(n_lit), 32'd8);
        advance_to(103);
        check("bright1 cnt7 an", 32'(an), 32'hB);
        advance_to(104);
        check("bright1 cnt8 an", 32'(an), 32'hF);

        // Suppression, decimal point and blanking on 0050
        start(16'h0050, 4'b0010, 4'h0, 2'd3);
        advance_to(5);
        check("lzs slot0 an", 32'(an), 32'hE);
        check("lzs slot0 sg", 32'(sg), 32'h01);
        check("lzs slot0 dp", 32'(dp), 32'h1);
        advance_to(20);
        check("lzs slot1 an", 32'(an), 32'hD);
        check("lzs slot1 sg", 32'(sg), 32'h24);
        check("lzs slot1 dp", 32'(dp), 32'h0);
        count_lit(32, 47, n_lit);
        advance_to(40);
        blank_in = 4'b0001;
        begin
            int n_hi;
            count_lit(48, 63, n_hi);
            n_lit = n_lit + n_hi;
        end
`ifdef SEG7_LZS_EN
        check("lzs slots2-3 lit", 32'(n_lit), 32'd0);
`else
        check("lzs slots2-3 lit", 32'(n_lit), 32'd32);
`endif
        advance_to(70);
        check("blank slot0 an", 32'(an), 32'hF);
        check("blank slot0 sg", 32'(sg), 32'h7F);
        check("blank slot0 dp", 32'(dp), 32'h1);
        advance_to(85);
        check("blank slot1 an", 32'(an), 32'hD);
        check("blank slot1 dp", 32'(dp), 32'h0);

        // Asynchronous reset between edges in slot 2, cycle 7
        start(16'h1234, 4'h0, 4'h0, 2'd3);
        advance_to(38);
        check("async pre an", 32'(an), 32'hB);
        #3;
        RST = 1'b1;
        #1;
        check("async an", 32'(an), 32'hF);
        check("async sg", 32'(sg), 32'h7F);
        check("async dp", 32'(dp), 32'h1);
        check("async frame_done", 32'(frame_done), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        k   = 0;
        advance_to(1);
        check("restart d0 an", 32'(an), 32'hE);
        check("restart d0 sg", 32'(sg), 32'h4C);
        advance_to(16);
        check("restart d1 an", 32'(an), 32'hD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
